multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller_pkg.sv | 47 ++++
 rtl/multicycle_controller_opcode_classifier.sv | 30 +++
 rtl/multicycle_controller.sv | 128 ++++++++++++
 tb/tb_multicycle_controller.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multicycle controller: state encoding, opcodes, ALUOp codes.
// Pure declarations, no logic; also used by the ALU decoder for its ALUOp inputs.
// No flow control.
package multicycle_controller_pkg;

  // Controller states; encodings 6 and 7 are unreachable and recover to FETCH.
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  // Supported major opcodes (instruction bits 6:0).
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  // ALUOp encodings shared with the ALU decoder.
  localparam logic [1:0] ALUOP_ADD    = 2'b00; // LW/SW/AUIPC address or PC add
  localparam logic [1:0] ALUOP_BRANCH = 2'b01; // branch compare
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10; // R/I type, decoded from funct fields
  localparam logic [1:0] ALUOP_JUMP   = 2'b11; // JAL/JALR/LUI

  // One-hot instruction class vector bit positions.
  localparam int unsigned NUM_CLS   = 9;
  localparam int unsigned CLS_R     = 0;
  localparam int unsigned CLS_I     = 1;
  localparam int unsigned CLS_LW    = 2;
  localparam int unsigned CLS_SW    = 3;
  localparam int unsigned CLS_BR    = 4;
  localparam int unsigned CLS_JAL   = 5;
  localparam int unsigned CLS_JALR  = 6;
  localparam int unsigned CLS_LUI   = 7;
  localparam int unsigned CLS_AUIPC = 8;

  typedef logic [NUM_CLS-1:0] cls_t;

endpackage

// File: rtl/multicycle_controller_opcode_classifier.sv
// Maps a 7-bit opcode to a one-hot instruction class plus a valid bit.
// Purely combinational, zero latency.
// No flow control.
module opcode_classifier
  import multicycle_controller_pkg::*;
(
  input  logic [6:0] opcode_i,
  output cls_t       cls_o,
  output logic       valid_o
);

  // Decode the opcode into exactly one class bit, or none when unsupported.
  always_comb begin
    cls_o = '0;
    case (opcode_i)
      OP_R:     cls_o[CLS_R]     = 1'b1;
      OP_I:     cls_o[CLS_I]     = 1'b1;
      OP_LW:    cls_o[CLS_LW]    = 1'b1;
      OP_SW:    cls_o[CLS_SW]    = 1'b1;
      OP_BR:    cls_o[CLS_BR]    = 1'b1;
      OP_JAL:   cls_o[CLS_JAL]   = 1'b1;
      OP_JALR:  cls_o[CLS_JALR]  = 1'b1;
      OP_LUI:   cls_o[CLS_LUI]   = 1'b1;
      OP_AUIPC: cls_o[CLS_AUIPC] = 1'b1;
      default:  cls_o = '0;
    endcase
    valid_o = |cls_o;
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle CPU control FSM: FETCH/DECODE/EXEC/MEM/WB plus a sticky TRAP state.
// One state per cycle; BR 3, R/I/JAL/JALR/LUI/AUIPC/SW 4, LW 5 cycles at full memory speed.
// mem_ready low in FETCH or MEM stalls the FSM one cycle per low cycle; ignored elsewhere.
module multicycle_controller
  import multicycle_controller_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] Opcode,
  input  logic       mem_ready,
  output logic [1:0] ALUOp,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       Branch,
  output logic       Jump,
  output logic       ALUSrc,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       illegal,
  output logic [2:0] state_o
);

  state_e     state_q, state_d;
  logic [6:0] op_q, op_d;
  logic [6:0] cls_op;
  cls_t       cls;
  logic       cls_vld;

  // In DECODE the classifier looks at the live opcode (only the transition uses it);
  // in every other state it looks at the latched op_q, which keeps outputs Moore.
  assign cls_op = (state_q == S_DECODE) ? Opcode : op_q;

  opcode_classifier u_classifier (
    .opcode_i (cls_op),
    .cls_o    (cls),
    .valid_o  (cls_vld)
  );

  logic is_r, is_i, is_lw, is_sw, is_br, is_jal, is_jalr, is_lui, is_auipc;
  assign is_r     = cls[CLS_R];
  assign is_i     = cls[CLS_I];
  assign is_lw    = cls[CLS_LW];
  assign is_sw    = cls[CLS_SW];
  assign is_br    = cls[CLS_BR];
  assign is_jal   = cls[CLS_JAL];
  assign is_jalr  = cls[CLS_JALR];
  assign is_lui   = cls[CLS_LUI];
  assign is_auipc = cls[CLS_AUIPC];

  // State and latched opcode; reset forces FETCH immediately, aborting any memory access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // Next-state and strobe decode; everything except the FETCH IR/PC pulse is Moore.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    ALUOp    = ALUOP_ADD;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    Branch   = 1'b0;
    Jump     = 1'b0;
    ALUSrc   = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    illegal  = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        // The IR/PC pulse is suppressed while reset is held so only MemRead shows.
        if (mem_ready && !reset) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        op_d    = Opcode;
        state_d = cls_vld ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        if (is_lw || is_sw || is_auipc) ALUOp = ALUOP_ADD;
        else if (is_br)                 ALUOp = ALUOP_BRANCH;
        else if (is_r || is_i)          ALUOp = ALUOP_FUNCT;
        else                            ALUOp = ALUOP_JUMP;
        ALUSrc = is_i | is_lw | is_sw | is_jalr | is_lui | is_auipc;
        Branch = is_br;
        Jump   = is_jal | is_jalr;
        if (is_lw || is_sw) state_d = S_MEM;
        else if (is_br)     state_d = S_FETCH;
        else                state_d = S_WB;
      end
      S_MEM: begin
        ALUOp    = ALUOP_ADD;
        ALUSrc   = 1'b1;
        MemRead  = is_lw;
        MemWrite = is_sw;
        if (mem_ready) state_d = is_lw ? S_WB : S_FETCH;
      end
      S_WB: begin
        RegWrite = 1'b1;
        MemtoReg = is_lw;
        state_d  = S_FETCH;
      end
      S_TRAP: begin
        illegal = 1'b1;
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

  localparam logic [6:0] T_R     = 7'b0110011;
  localparam logic [6:0] T_I     = 7'b0010011;
  localparam logic [6:0] T_LW    = 7'b0000011;
  localparam logic [6:0] T_SW    = 7'b0100011;
  localparam logic [6:0] T_BR    = 7'b1100011;
  localparam logic [6:0] T_JAL   = 7'b1101111;
  localparam logic [6:0] T_JALR  = 7'b1100111;
  localparam logic [6:0] T_LUI   = 7'b0110111;
  localparam logic [6:0] T_AUIPC = 7'b0010111;
  localparam logic [6:0] T_BAD   = 7'b1111111;

  // Strobe vector bit positions: {IRWrite,PCWrite,Branch,Jump,ALUSrc,MemRead,MemWrite,MemtoReg,RegWrite}
  localparam int B_IR = 8, B_PC = 7, B_BR = 6, B_JMP = 5, B_SRC = 4;
  localparam int B_MR = 3, B_MW = 2, B_M2R = 1, B_RW = 0;

  typedef struct {
    logic       mr;
    logic [6:0] opc;
    logic [2:0] st;
    logic [1:0] alu;
    logic [8:0] stb;
    logic       ill;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] Opcode;
  logic       mem_ready;
  logic [1:0] ALUOp;
  logic       IRWrite, PCWrite, Branch, Jump, ALUSrc;
  logic       MemRead, MemWrite, MemtoReg, RegWrite, illegal;
  logic [2:0] state_o;
  logic [8:0] stb;

  int n_vec = 0;
  int n_bad = 0;
  exp_t sb_q[$];

  multicycle_controller dut (
    .clk       (clk),
    .reset     (reset),
    .Opcode    (Opcode),
    .mem_ready (mem_ready),
    .ALUOp     (ALUOp),
    .IRWrite   (IRWrite),
    .PCWrite   (PCWrite),
    .Branch    (Branch),
    .Jump      (Jump),
    .ALUSrc    (ALUSrc),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .MemtoReg  (MemtoReg),
    .RegWrite  (RegWrite),
    .illegal   (illegal),
    .state_o   (state_o)
  );

  assign stb = {IRWrite, PCWrite, Branch, Jump, ALUSrc, MemRead, MemWrite, MemtoReg, RegWrite};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input logic mr, input logic [6:0] opc, input logic [2:0] st,
                      input logic [1:0] alu, input logic [8:0] s, input logic ill);
    exp_t e;
    e.mr = mr; e.opc = opc; e.st = st; e.alu = alu; e.stb = s; e.ill = ill;
    sb_q.push_back(e);
  endtask

  // Reference model: expected per-cycle trace of one instruction.
  task automatic build(input logic [6:0] op, input int fw, input int mw);
    logic r, i, lw, sw, br, jal, jalr, lui, auipc, legal;
    logic [1:0] alu;
    logic [8:0] s;
    r = (op == T_R); i = (op == T_I); lw = (op == T_LW); sw = (op == T_SW);
    br = (op == T_BR); jal = (op == T_JAL); jalr = (op == T_JALR);
    lui = (op == T_LUI); auipc = (op == T_AUIPC);
    legal = r | i | lw | sw | br | jal | jalr | lui | auipc;
    for (int k = 0; k < fw; k++) begin
      s = '0; s[B_MR] = 1'b1;
      push(1'b0, 7'($urandom), 3'd0, 2'b00, s, 1'b0);
    end
    s = '0; s[B_MR] = 1'b1; s[B_IR] = 1'b1; s[B_PC] = 1'b1;
    push(1'b1, 7'($urandom), 3'd0, 2'b00, s, 1'b0);
    push(1'($urandom_range(0, 1)), op, 3'd1, 2'b00, 9'd0, 1'b0);
    if (!legal) begin
      for (int k = 0; k < 10; k++)
        push(1'($urandom_range(0, 1)), 7'($urandom), 3'd5, 2'b00, 9'd0, 1'b1);
      return;
    end
    if (lw || sw || auipc) alu = 2'b00;
    else if (br)           alu = 2'b01;
    else if (r || i)       alu = 2'b10;
    else                   alu = 2'b11;
    s = '0;
    s[B_SRC] = i | lw | sw | jalr | lui | auipc;
    s[B_BR]  = br;
    s[B_JMP] = jal | jalr;
    push(1'($urandom_range(0, 1)), 7'($urandom), 3'd2, alu, s, 1'b0);
    if (lw || sw) begin
      s = '0; s[B_SRC] = 1'b1; s[B_MR] = lw; s[B_MW] = sw;
      for (int k = 0; k < mw; k++) push(1'b0, 7'($urandom), 3'd3, 2'b00, s, 1'b0);
      push(1'b1, 7'($urandom), 3'd3, 2'b00, s, 1'b0);
    end
    if (!br && !sw) begin
      s = '0; s[B_RW] = 1'b1; s[B_M2R] = lw;
      push(1'($urandom_range(0, 1)), 7'($urandom), 3'd4, 2'b00, s, 1'b0);
    end
  endtask

  // Drive one instruction, compare each cycle against the scoreboard, then
  // measure the DUT's instruction length (-1 expected cycles = trapping op).
  task automatic run_instr(input string tag, input logic [6:0] op, input int fw,
                           input int mw, input int exp_cyc);
    exp_t e;
    int   n, meas, pcw;
    logic seen;
    build(op, fw, mw);
    n = sb_q.size(); meas = -1; pcw = 0; seen = 1'b0;
    for (int k = 0; k < n; k++) begin
      e = sb_q.pop_front();
      @(posedge clk); #1;
      mem_ready = e.mr; Opcode = e.opc;
      @(negedge clk);
      chk({tag, ".state"}, 32'(state_o), 32'(e.st));
      chk({tag, ".aluop"}, 32'(ALUOp), 32'(e.alu));
      chk({tag, ".strobes"}, 32'(stb), 32'(e.stb));
      chk({tag, ".illegal"}, 32'(illegal), 32'(e.ill));
      chk({tag, ".rd_wr_excl"}, 32'(MemRead & MemWrite), 32'd0);
      chk({tag, ".rw_mw_excl"}, 32'(RegWrite & MemWrite), 32'd0);
      if (PCWrite) pcw++;
      if (state_o != 3'd0) seen = 1'b1;
      else if (seen && meas < 0) meas = k;
    end
    if (exp_cyc >= 0) begin
      @(posedge clk); #1;
      mem_ready = 1'b0;
      @(negedge clk);
      if (meas < 0 && seen && state_o == 3'd0) meas = n;
      chk({tag, ".cycles"}, 32'(meas), 32'(exp_cyc));
      chk({tag, ".pcwrite_cnt"}, 32'(pcw), 32'd1);
    end
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b0; Opcode = '0;
    #3;
    chk("rst.state", 32'(state_o), 32'd0);
    chk("rst.strobes", 32'(stb), 32'h008);
    chk("rst.aluop", 32'(ALUOp), 32'd0);
    chk("rst.illegal", 32'(illegal), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_instr("r",     T_R,     0, 0, 4);
    run_instr("i",     T_I,     1, 0, 5);
    run_instr("lw",    T_LW,    0, 2, 7);
    run_instr("sw",    T_SW,    0, 0, 4);
    run_instr("sw_w",  T_SW,    1, 1, 6);
    run_instr("br",    T_BR,    0, 0, 3);
    run_instr("jal",   T_JAL,   0, 0, 4);
    run_instr("jalr",  T_JALR,  0, 0, 4);
    run_instr("lui",   T_LUI,   0, 0, 4);
    run_instr("auipc", T_AUIPC, 2, 0, 6);
    run_instr("lw0",   T_LW,    0, 0, 5);
    run_instr("trap",  T_BAD,   0, 0, -1);

    // Reset pulse out of TRAP.
    @(posedge clk); #1;
    reset = 1'b1; mem_ready = 1'b0;
    #1;
    chk("trap_rst.state", 32'(state_o), 32'd0);
    chk("trap_rst.illegal", 32'(illegal), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // SW interrupted by reset while waiting in MEM.
    @(posedge clk); #1;
    Opcode = T_SW; mem_ready = 1'b1;   // FETCH completes
    @(posedge clk); #1;                // DECODE latches SW
    @(posedge clk); #1;                // EXEC
    mem_ready = 1'b0;
    @(posedge clk); #1;                // MEM, stalled
    @(negedge clk);
    chk("mid_mem.state", 32'(state_o), 32'd3);
    chk("mid_mem.memwrite", 32'(MemWrite), 32'd1);
    #2;
    reset = 1'b1; mem_ready = 1'b1;
    #1;
    chk("async_rst.memwrite", 32'(MemWrite), 32'd0);
    chk("async_rst.state", 32'(state_o), 32'd0);
    chk("async_rst.strobes", 32'(stb), 32'h008);
    @(posedge clk); #1;
    chk("held_rst.strobes", 32'(stb), 32'h008);
    chk("held_rst.state", 32'(state_o), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst.fetch", 32'(state_o), 32'd1);
    chk("post_rst.memwrite", 32'(MemWrite), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
